wb_bus_arbiter: RTL

- Two-master to one-slave Wishbone (classic, single-cycle handshake) arbiter.
- Shares the single SRAM/peripheral bus between the instruction-fetch master (M0) and the data-memory master (M1) of the pipeline.
- Grants the bus for a whole cycle (cyc-locked).
- Muxes the granted master onto the slave port and routes ack/data back to that master only.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arb_pick.sv | 34 +++
 rtl/wb_bus_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Optional build macro: WB_ARB_ROUND_ROBIN_EN (round-robin tie-break).
package wb_arb_pkg;

    localparam int NUM_MASTERS = 2;

    // One-hot encoding doubles as the debug grant vector.
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } grant_t;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational chooser for the Wishbone arbiter.
// WB_ARB_ROUND_ROBIN_EN selects a round-robin tie-break; otherwise M1 wins ties.
module wb_arb_pick
    import wb_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last,
    output grant_t                 pick
);

`ifndef WB_ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        pick = GNT_NONE;
        unique case (req)
            2'b01: pick = GNT_M0;
            2'b10: pick = GNT_M1;
            2'b11: begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                // Hand the tie to whichever master did not own the bus last.
                pick = last ? GNT_M0 : GNT_M1;
`else
                // Data accesses must never starve behind instruction fetch.
                pick = GNT_M1;
`endif
            end
            default: pick = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master to one-slave classic Wishbone arbiter with cyc-locked grants.
// Optional build macro: WB_ARB_ROUND_ROBIN_EN (round-robin tie-break).
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    output logic                    m0_ack_o,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    output logic                    m1_ack_o,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    input  logic                    s_ack_i,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,

    output logic [1:0]              grant_o
);

    grant_t                 grant_reg;
    grant_t                 grant_next;
    grant_t                 pick;
    logic [NUM_MASTERS-1:0] req;
    logic                   last_sel;

    // Only cyc counts as a request; a stray stb is ignored.
    assign req = {m1_cyc_i, m0_cyc_i};

    wb_arb_pick u_pick (
        .req  (req),
        .last (last_sel),
        .pick (pick)
    );

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic last_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg <= 1'b0;
        end else if (grant_reg == GNT_NONE && req != '0) begin
            last_reg <= (pick == GNT_M1);
        end
    end

    assign last_sel = last_reg;
`else
    assign last_sel = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_reg <= GNT_NONE;
        end else begin
            grant_reg <= grant_next;
        end
    end

    always_comb begin
        grant_next = grant_reg;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        m0_ack_o   = 1'b0;
        m0_dat_o   = '0;
        m1_ack_o   = 1'b0;
        m1_dat_o   = '0;
        unique case (grant_reg)
            GNT_NONE: begin
                if (req != '0) grant_next = pick;
            end
            GNT_M0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                // Release always passes through idle: one-cycle bubble between owners.
                if (!m0_cyc_i) grant_next = GNT_NONE;
            end
            GNT_M1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                if (!m1_cyc_i) grant_next = GNT_NONE;
            end
            default: grant_next = GNT_NONE;
        endcase
    end

    assign grant_o = grant_reg;

endmodule
